adc_report_sequencer: RTL
=========================

# adc_report_sequencer

Periodic sampling controller between the ADC receiver and the UART transmitter. On a programmable tick it requests one ADC conversion, captures the 12-bit result, and streams it to the UART as ASCII text terminated by CR LF, one byte per UART handshake. It replaces ad-hoc counter-driven sequencing in the top level with a single FSM that guarantees no request or byte is issued while the previous one is in flight.

## Interface
Parameters:
- SAMPLE_PERIOD, 5000000, clocks between sample ticks (100 ms at 50 MHz); must be ≥ 2
- ADC_TIMEOUT, 1000, max clocks spent in REQ+CONV before abort

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock, synchronous, active-low
- i_enable  in  1  allow sample ticks
- i_adc_cmd  in  6  config word for the ADC; registered into o_adc_tx_bits at each tick
- o_adc_tx_bits  out  6  config word to ADC receiver
- o_adc_request  out  1  conversion request, held until acknowledged
- i_adc_conv_busy  in  1  ADC conversion-in-process (acts as request acknowledge)
- i_adc_dv  in  1  one-cycle ADC result valid
- i_adc_data  in  12  ADC result
- o_uart_byte  out  8  byte to UART transmitter
- o_uart_dv  out  1  UART data valid
- i_uart_dv_ack  in  1  UART "good to reset dv"
- i_uart_done  in  1  UART send complete pulse
- o_busy  out  1  FSM not in IDLE
- o_adc_err  out  1  one-cycle pulse on ADC timeout
- o_overrun_cnt  out  8  ticks dropped while busy, saturating

## Operation
- Reset values: o_adc_tx_bits=6'b100000, o_adc_request=0, o_uart_byte=0, o_uart_dv=0, o_busy=0, o_adc_err=0, o_overrun_cnt=0; FSM=IDLE; period counter=0; byte index=0; sample register=0.
- Period counter counts 0..SAMPLE_PERIOD-1 while i_enable=1, wraps to 0; held at 0 while i_enable=0. Tick = counter==SAMPLE_PERIOD-1.
- States: IDLE, REQ, CONV, LOAD, SEND, WAIT_DONE.
- IDLE: on tick → REQ, latch i_adc_cmd, o_adc_request=1, clear timeout counter.
- REQ: on i_adc_conv_busy=1 → CONV, o_adc_request=0.
- CONV: on i_adc_dv=1 → LOAD, latch i_adc_data, byte index=0.
- LOAD: drive o_uart_byte from index, o_uart_dv=1 → SEND.
- SEND: on i_uart_dv_ack=1 → WAIT_DONE, o_uart_dv=0. i_uart_done ignored here.
- WAIT_DONE: on i_uart_done=1: if last index → IDLE, else index+1 → LOAD.
- Default frame (14 bytes): bits 11..0 MSB first as 8'h30+bit, then 8'h0D, 8'h0A.
- Timeout: counter runs in REQ and CONV; reaching ADC_TIMEOUT → o_adc_err=1 one cycle, o_adc_request=0, → IDLE, nothing sent.
- Tick while not IDLE: tick dropped, o_overrun_cnt+1, saturates at 255.
- i_enable deasserted mid-report: current report completes; no new ticks.
- Reset mid-operation: all state to reset values at the next edge; o_uart_dv and o_adc_request drop immediately.

## Timing
- Tick in cycle N → o_adc_request=1, o_busy=1 from N+1.
- i_adc_conv_busy sampled high in cycle M → o_adc_request=0 from M+1.
- i_adc_dv sampled in cycle D → o_uart_dv=1 with first byte from D+2 (LOAD at D+1).
- i_uart_dv_ack sampled in A → o_uart_dv=0 from A+1; o_uart_byte stable from LOAD until next LOAD.
- i_uart_done of last byte in cycle F → o_busy=0 from F+1; a tick in cycle F still counts as overrun.
- Min inter-byte gap: done in cycle F → next o_uart_dv=1 at F+2.

## Configuration
- REPORT_HEX_EN defined: frame is 5 bytes — 3 uppercase hex digits of bits 11..8, 7..4, 3..0 (0–9 → 8'h30+n, A–F → 8'h37+n), then 8'h0D, 8'h0A.
- Undefined: 14-byte binary frame as above.

## Test plan
- Reset then enable, SAMPLE_PERIOD=100, ADC returns 12'hAB3 → UART bytes "101010110011",0D,0A; o_busy low after last done.
- REPORT_HEX_EN, data 12'h0F9 → bytes 30,46,39,0D,0A.
- Never assert i_adc_conv_busy, ADC_TIMEOUT=50 → o_adc_err pulse 50 cycles after request; no o_uart_dv; next tick retries normally.
- UART done delayed 300 cycles per byte, SAMPLE_PERIOD=100 → o_overrun_cnt increments each dropped tick, saturates at 255, frames uncorrupted.
- i_rst_n low during SEND of byte 5 → next cycle o_uart_dv=0, o_busy=0, o_overrun_cnt=0; after release first report restarts at byte 0.
- Ack and done in same cycle while in SEND → only ack honoured; FSM waits for a later done.

Source files
------------

// File: rtl/adc_report_sequencer.sv
// Periodic ADC sample-and-report sequencer: request one conversion per tick, stream result to UART as ASCII + CR LF.
// Optional build macro REPORT_HEX_EN selects a 3-digit uppercase hex frame instead of the 12-digit binary frame.
module adc_report_sequencer #(
    parameter int SAMPLE_PERIOD = 5000000,
    parameter int ADC_TIMEOUT   = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [5:0]  i_adc_cmd,
    output logic [5:0]  o_adc_tx_bits,
    output logic        o_adc_request,
    input  logic        i_adc_conv_busy,
    input  logic        i_adc_dv,
    input  logic [11:0] i_adc_data,
    output logic [7:0]  o_uart_byte,
    output logic        o_uart_dv,
    input  logic        i_uart_dv_ack,
    input  logic        i_uart_done,
    output logic        o_busy,
    output logic        o_adc_err,
    output logic [7:0]  o_overrun_cnt
);

`ifdef REPORT_HEX_EN
    localparam int LAST_IDX = 4;
`else
    localparam int LAST_IDX = 13;
`endif
    localparam int PER_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CONV,
        LOAD,
        SEND,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic [PER_W-1:0]   period_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [3:0]         byte_idx;
    logic [11:0]        sample;
    logic               adc_request_q;
    logic               uart_dv_q;
    logic               tick;
    logic               tmo_expired;

    function automatic logic [7:0] frame_byte(input logic [11:0] s, input logic [3:0] idx);
        logic [7:0] b;
        logic [3:0] nib;
        b   = 8'h0A;
        nib = 4'h0;
`ifdef REPORT_HEX_EN
        case (idx)
            4'd0:    nib = s[11:8];
            4'd1:    nib = s[7:4];
            4'd2:    nib = s[3:0];
            default: nib = 4'h0;
        endcase
        if (idx < 4'd3)
            b = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        else if (idx == 4'd3)
            b = 8'h0D;
`else
        nib = 4'd11 - idx;
        if (idx < 4'd12)
            b = 8'h30 + {7'd0, s[nib]};
        else if (idx == 4'd12)
            b = 8'h0D;
`endif
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign tick        = i_enable && (period_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign tmo_expired = (tmo_cnt >= TMO_W'(ADC_TIMEOUT - 1));

    // Handshake outputs are masked by reset so they fall in the same cycle reset is asserted.
    assign o_adc_request = adc_request_q & i_rst_n;
    assign o_uart_dv     = uart_dv_q & i_rst_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable || tick)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_adc_tx_bits <= 6'b100000;
            adc_request_q <= 1'b0;
            o_uart_byte   <= 8'h00;
            uart_dv_q     <= 1'b0;
            o_busy        <= 1'b0;
            o_adc_err     <= 1'b0;
            o_overrun_cnt <= 8'h00;
            tmo_cnt       <= '0;
            byte_idx      <= 4'd0;
            sample        <= 12'h000;
        end else begin
            o_adc_err <= 1'b0;
            if (tick && state != IDLE)
                o_overrun_cnt <= sat_inc(o_overrun_cnt);

            case (state)
                IDLE: begin
                    if (tick) begin
                        state         <= REQ;
                        o_adc_tx_bits <= i_adc_cmd;
                        adc_request_q <= 1'b1;
                        o_busy        <= 1'b1;
                        tmo_cnt       <= '0;
                    end
                end
                REQ: begin
                    if (i_adc_conv_busy) begin
                        state         <= CONV;
                        adc_request_q <= 1'b0;
                        tmo_cnt       <= tmo_cnt + 1'b1;
                    end else if (tmo_expired) begin
                        state         <= IDLE;
                        adc_request_q <= 1'b0;
                        o_adc_err     <= 1'b1;
                        o_busy        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CONV: begin
                    // A result arriving on the expiry cycle still wins over the abort.
                    if (i_adc_dv) begin
                        state    <= LOAD;
                        sample   <= i_adc_data;
                        byte_idx <= 4'd0;
                    end else if (tmo_expired) begin
                        state     <= IDLE;
                        o_adc_err <= 1'b1;
                        o_busy    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    o_uart_byte <= frame_byte(sample, byte_idx);
                    uart_dv_q   <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (i_uart_dv_ack) begin
                        uart_dv_q <= 1'b0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_uart_done) begin
                        if (byte_idx == 4'(LAST_IDX)) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
